// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The ovf signal exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_ADDSUB_OVF_EN
    modport master (output start, mode, a, b, input busy, done, result, cout, ovf);
    modport slave  (input start, mode, a, b, output busy, done, result, cout, ovf);
`else
    modport master (output start, mode, a, b, input busy, done, result, cout);
    modport slave  (input start, mode, a, b, output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell plus a carry/borrow
// flop, one bit per clock, LSB first. Optional two's-complement overflow output
// is enabled by defining SERIAL_ADDSUB_OVF_EN.
//
//  state | meaning
//  IDLE  | waiting for start; operands latched on the accepting edge
//  RUN   | shifting one bit per clock, WIDTH clocks
//  DONE  | one-cycle done pulse; result/cout valid
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_addsub_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res_q;
    logic             sub_mode;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             abit;
    logic             bbit;
    logic             sbit;
    logic             c_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q;
`endif

    assign last = (cnt == CW'(WIDTH - 1));
    assign abit = sh_a[0];
    assign bbit = sh_b[0];

    // Single full-adder / full-subtractor cell.
    always_comb begin
        sbit  = abit ^ bbit ^ carry;
        c_nxt = sub_mode ? ((~abit & bbit) | (~(abit ^ bbit) & carry))
                         : ((abit & bbit) | (carry & (abit ^ bbit)));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start outside IDLE is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, result shift-in at the MSB, carry flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a     <= '0;
            sh_b     <= '0;
            res_q    <= '0;
            sub_mode <= 1'b0;
            carry    <= 1'b0;
            cout_q   <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (bus.start) begin
                sh_a     <= bus.a;
                sh_b     <= bus.b;
                sub_mode <= bus.mode;
                carry    <= 1'b0;
                cnt      <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
                ovf_q    <= 1'b0;
`endif
            end
        end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            res_q <= {sbit, res_q[WIDTH-1:1]};
            carry <= c_nxt;
            cnt   <= cnt + CW'(1);
            if (last) begin
                cout_q <= c_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
                // carry currently holds the carry into the MSB.
                ovf_q  <= carry ^ c_nxt;
`endif
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = res_q;
    assign bus.cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
    logic clk;
    logic rst_n;

    serial_addsub_if #(.WIDTH(4)) if4 ();
    serial_addsub_if #(.WIDTH(8)) if8 ();

    serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt4 = 0;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor, WIDTH=4 instance.
    always @(negedge clk) begin
        if (if4.done) begin
            exp_t e;
            done_cnt4++;
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done4_unexpected actual=1 required=0");
            end else begin
                e = q4.pop_front();
                chk("w4_result", {28'd0, if4.result}, {28'd0, e.res[3:0]});
                chk("w4_cout", {31'd0, if4.cout}, {31'd0, e.cout});
`ifdef SERIAL_ADDSUB_OVF_EN
                chk("w4_ovf", {31'd0, if4.ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Scoreboard monitor, WIDTH=8 instance.
    always @(negedge clk) begin
        if (if8.done) begin
            exp_t e;
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done8_unexpected actual=1 required=0");
            end else begin
                e = q8.pop_front();
                chk("w8_result", {24'd0, if8.result}, {24'd0, e.res});
                chk("w8_cout", {31'd0, if8.cout}, {31'd0, e.cout});
`ifdef SERIAL_ADDSUB_OVF_EN
                chk("w8_ovf", {31'd0, if8.ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // One WIDTH=4 op with latency and busy-length checks; called at a negedge with DUT idle.
    task automatic run4(input vec_t v);
        int n;
        int lat;
        int bcnt;
        q4.push_back('{res: {4'd0, v.res}, cout: v.cout, ovf: v.ovf});
        if4.mode  = v.mode;
        if4.a     = v.a;
        if4.b     = v.b;
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        if4.a     = ~v.a;
        if4.b     = ~v.b;
        if4.mode  = ~v.mode;
        n = 1;
        lat = -1;
        bcnt = 0;
        while (if4.busy && n < 40) begin
            bcnt++;
            if (if4.done && lat < 0) lat = n - 1;
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL w4_timeout actual=busy required=idle");
        end
        chk("w4_latency", lat, 4);
        chk("w4_busy_cycles", bcnt, 5);
    endtask

    task automatic wait_idle4();
        int n;
        n = 0;
        while (if4.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL w4_idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y);
        int n;
        logic [8:0] full;
        logic       o;
        n = 0;
        while (if8.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL w8_idle_timeout actual=busy required=idle");
        end
        full = m ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        o = m ? ((x[7] != y[7]) && (full[7] != x[7])) : ((x[7] == y[7]) && (full[7] != x[7]));
        q8.push_back('{res: full[7:0], cout: full[8], ovf: o});
        if8.mode  = m;
        if8.a     = x;
        if8.b     = y;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        if8.a     = 8'($urandom);
        if8.b     = 8'($urandom);
        if8.mode  = ~m;
    endtask

    initial begin
        int d0;
        int n;
        vecs[0] = '{mode: 1'b0, a: 4'd5, b: 4'd3, res: 4'd8,  cout: 1'b0, ovf: 1'b1};
        vecs[1] = '{mode: 1'b1, a: 4'd9, b: 4'd9, res: 4'd0,  cout: 1'b0, ovf: 1'b0};
        vecs[2] = '{mode: 1'b0, a: 4'd7, b: 4'd1, res: 4'd8,  cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{mode: 1'b1, a: 4'd8, b: 4'd1, res: 4'd7,  cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{mode: 1'b0, a: 4'd2, b: 4'd3, res: 4'd5,  cout: 1'b0, ovf: 1'b0};
        vecs[5] = '{mode: 1'b1, a: 4'd3, b: 4'd5, res: 4'd14, cout: 1'b1, ovf: 1'b0};

        rst_n = 1'b0;
        if4.start = 1'b0; if4.mode = 1'b0; if4.a = '0; if4.b = '0;
        if8.start = 1'b0; if8.mode = 1'b0; if8.a = '0; if8.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, if4.busy}, 0);
        chk("rst_done", {31'd0, if4.done}, 0);
        chk("rst_result", {28'd0, if4.result}, 0);
        chk("rst_cout", {31'd0, if4.cout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run4(vecs[i]);

        // Reset at the 2nd RUN edge aborts with no done pulse.
        d0 = done_cnt4;
        chk("pre_abort_result", {28'd0, if4.result}, 14);
        if4.mode = 1'b0; if4.a = 4'd4; if4.b = 4'd4; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, if4.busy}, 0);
        chk("abort_done", {31'd0, if4.done}, 0);
        chk("abort_result", {28'd0, if4.result}, 0);
        chk("abort_cout", {31'd0, if4.cout}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt4 - d0, 0);
        run4('{mode: 1'b0, a: 4'd6, b: 4'd7, res: 4'd13, cout: 1'b0, ovf: 1'b1});

        // 15+1 with a start pulse during RUN that must be ignored.
        d0 = done_cnt4;
        q4.push_back('{res: 8'd0, cout: 1'b1, ovf: 1'b0});
        if4.mode = 1'b0; if4.a = 4'd15; if4.b = 4'd1; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        if4.a = 4'd1; if4.b = 4'd1; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        wait_idle4();
        repeat (12) @(negedge clk);
        chk("ignored_start_dones", done_cnt4 - d0, 1);
        chk("ignored_start_result", {28'd0, if4.result}, 0);
        chk("ignored_start_busy", {31'd0, if4.busy}, 0);

        // WIDTH=8 sweep: every a value once per mode, random b.
        for (int i = 0; i < 256; i++) op8(1'b0, 8'(i), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 256; i++) op8(1'b1, 8'(i), 8'($urandom_range(0, 255)));
        op8(1'b1, 8'd200, 8'd200);
        n = 0;
        while ((q8.size() != 0 || if8.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w8_drain", q8.size(), 0);
        chk("w4_drain", q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
